// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ SPI host-side reader: FSM encodings,
// SPI mode constants and the default package size of the slave ring FIFO.
package daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INTR = 3'd1,
    ST_SETUP     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  // Mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on leading edge).
  localparam int   SPI_MODE = 0;
  localparam logic SCK_IDLE = (SPI_MODE >= 2);

  // Bytes per package streamed by the slave ring FIFO.
  localparam int PKG_BYTES_DEFAULT = 11552;

  // States in which a package transaction is in progress.
  function automatic logic is_busy(state_t s);
    return !(s == ST_IDLE || s == ST_WAIT_INTR);
  endfunction

  // States in which chip select is driven active (low).
  function automatic logic cs_active(state_t s);
    return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_sck_div.sv
// SPI clock divider: sck toggles every CLK_DIV cycles while enabled and
// returns to idle immediately when disabled. Strobes flag the cycle whose
// closing edge drives sck 0->1 (rise) or 1->0 (fall).
module spi_sck_div
  import daq_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == LAST);

  // Half-period counter and sck toggle.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = SCK_IDLE;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= SCK_IDLE;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign rise_stb_o = wrap && !sck_q;
  assign fall_stb_o = wrap && sck_q;

endmodule

// File: rtl/spi_pkg_reader.sv
// SPI master that reads one fixed-size package from the FPGA slave per
// rising edge of its package-ready interrupt, emits the bytes as a strobed
// stream and optionally checks the slave's incrementing test pattern.
module spi_pkg_reader
  import daq_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int PKG_BYTES = PKG_BYTES_DEFAULT,
  parameter int CNT_W     = 14,
  parameter int CS_SETUP  = 4,
  parameter int CS_GAP    = 8,
  parameter int CHECK_INC = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start_en,
  input  logic             intr_in,
  input  logic             miso,
  output logic             cs_n,
  output logic             sck,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             pkg_done,
  output logic             busy,
  output logic             overrun,
  output logic [15:0]      err_cnt
);

  localparam int T_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int TW    = $clog2(T_MAX + 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             intr_rise;
  logic             cs_n_q, busy_q, pkg_done_q, overrun_q;
  logic [6:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       byte_out_q;
  logic             byte_valid_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             sck_en, sck_w, rise_stb, fall_stb;
  logic [7:0]       new_byte;
  logic             byte_last, last_fall, setup_entry;

  assign intr_rise   = sync2_q && !prev_q;
  assign sck_en      = (state_q == ST_SHIFT);
  assign new_byte    = {shift_q, miso};
  assign byte_last   = rise_stb && (bit_cnt_q == 3'd7);
  assign last_fall   = fall_stb && (byte_cnt_q == CNT_W'(PKG_BYTES));
  assign setup_entry = (state_q == ST_WAIT_INTR) && (state_d == ST_SETUP);

  spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .en_i       (sck_en),
    .sck_o      (sck_w),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Next-state logic; the timer restarts on every state change.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    case (state_q)
      ST_IDLE:      if (start_en) state_d = ST_WAIT_INTR;
      ST_WAIT_INTR: if (!start_en) state_d = ST_IDLE;
                    else if (intr_rise) state_d = ST_SETUP;
      ST_SETUP:     if (timer_q == TW'(CS_SETUP - 1)) state_d = ST_SHIFT;
      ST_SHIFT:     if (last_fall) state_d = ST_HOLD;
      ST_HOLD:      state_d = ST_GAP;
      ST_GAP:       if (timer_q == TW'(CS_GAP - 1))
                      state_d = start_en ? ST_WAIT_INTR : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // FSM register plus registered (glitch-free) control outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      pkg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cs_n_q     <= !cs_active(state_d);
      busy_q     <= is_busy(state_d);
      pkg_done_q <= (state_q == ST_SHIFT) && (state_d == ST_HOLD);
    end
  end

  // Interrupt synchroniser, edge history and sticky overrun flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q <= intr_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (intr_rise && is_busy(state_q)) overrun_q <= 1'b1;
    end
  end

  // MSB-first shift register; a byte is published on its 8th sample edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      if (setup_entry) begin
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end else if (rise_stb) begin
        shift_q   <= new_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_out_q   <= new_byte;
          byte_valid_q <= 1'b1;
          byte_cnt_q   <= byte_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  generate
    if (CHECK_INC != 0) begin : g_chk
      logic [7:0]  ref_q;
      logic [15:0] err_q;

      // Pattern checker: byte 0 seeds the reference, later bytes must be
      // ref+1 mod 256; a mismatch counts and resyncs to the received byte.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          ref_q <= '0;
          err_q <= '0;
        end else if (byte_last) begin
          ref_q <= new_byte;
          if ((byte_cnt_q != '0) && (new_byte != ref_q + 8'd1) && (err_q != 16'hFFFF))
            err_q <= err_q + 16'd1;
        end
      end

      assign err_cnt = err_q;
    end else begin : g_nochk
      assign err_cnt = 16'h0000;
    end
  endgenerate

  assign cs_n       = cs_n_q;
  assign sck        = sck_w;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_cnt   = byte_cnt_q;
  assign pkg_done   = pkg_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_pkg_reader.sv
// Scoreboard bench for spi_pkg_reader with a mode-0 SPI slave model.
module tb_spi_pkg_reader;

  localparam int CLK_DIV    = 2;
  localparam int PKG_BYTES  = 16;
  localparam int CNT_W      = 14;
  localparam int CS_SETUP   = 4;
  localparam int CS_GAP     = 8;
  localparam int CS_LOW_CYC = CS_SETUP + PKG_BYTES * 16 * CLK_DIV + 1;  // 517

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start_en = 1'b0;
  logic             intr_in = 1'b0;
  logic             miso;
  logic             cs_n, sck, byte_valid, pkg_done, busy, overrun;
  logic [7:0]       byte_out;
  logic [CNT_W-1:0] byte_cnt;
  logic [15:0]      err_cnt;

  always #10 sys_clk = ~sys_clk;

  spi_pkg_reader #(
    .CLK_DIV(CLK_DIV), .PKG_BYTES(PKG_BYTES), .CNT_W(CNT_W),
    .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .CHECK_INC(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_en(start_en),
    .intr_in(intr_in), .miso(miso), .cs_n(cs_n), .sck(sck),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_cnt(byte_cnt),
    .pkg_done(pkg_done), .busy(busy), .overrun(overrun), .err_cnt(err_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Slave model: MSB of byte 0 presented at cs_n fall, shift on sck fall.
  logic [7:0] slave_bytes [PKG_BYTES];
  int bit_idx = 0;
  always @(posedge cs_n or negedge sck) begin
    if (cs_n) bit_idx = 0;
    else      bit_idx = bit_idx + 1;
  end
  assign miso = (bit_idx < PKG_BYTES * 8) ? slave_bytes[bit_idx / 8][7 - (bit_idx % 8)] : 1'b0;

  // Scoreboard queues filled by stimulus.
  logic [7:0] exp_bytes [$];
  int         exp_done_err [$];
  int         exp_falls = 0;

  // Monitor state.
  int         bytes_seen = 0, done_seen = 0, cs_falls = 0;
  int         low_cnt = 0, high_cnt = 0;
  logic       cs_prev = 1'b1;
  bit         seen_first = 1'b0;
  bit         chk_len = 1'b1;
  logic [7:0] mon_b;
  int         mon_e;

  // Monitor: pops expectations whenever the DUT presents a byte or package end.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (byte_valid) begin
        bytes_seen++;
        if (exp_bytes.size() == 0) check("unexpected byte_valid", 1, 0);
        else begin
          mon_b = exp_bytes.pop_front();
          check("byte_out", int'(byte_out), int'(mon_b));
        end
      end
      if (pkg_done) begin
        done_seen++;
        if (exp_done_err.size() == 0) check("unexpected pkg_done", 1, 0);
        else begin
          mon_e = exp_done_err.pop_front();
          check("byte_cnt at pkg_done", int'(byte_cnt), PKG_BYTES);
          check("err_cnt at pkg_done", int'(err_cnt), mon_e);
        end
      end
    end
    if (!cs_n) begin
      if (cs_prev) begin
        cs_falls++;
        if (seen_first) begin
          tests++;
          if (high_cnt < CS_GAP) begin
            fails++;
            $display("FAIL cs_n high gap: got %0d cycles, required >= %0d", high_cnt, CS_GAP);
          end
        end
        seen_first = 1'b1;
        low_cnt = 0;
      end
      low_cnt++;
    end else begin
      if (!cs_prev) begin
        if (chk_len) check("cs_n low cycles", low_cnt, CS_LOW_CYC);
        high_cnt = 0;
      end
      high_cnt++;
    end
    cs_prev = cs_n;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic load_inc(input logic [7:0] first);
    for (int i = 0; i < PKG_BYTES; i++) slave_bytes[i] = first + 8'(i);
  endtask

  task automatic push_exp(input int err_after);
    for (int i = 0; i < PKG_BYTES; i++) exp_bytes.push_back(slave_bytes[i]);
    exp_done_err.push_back(err_after);
    exp_falls++;
  endtask

  task automatic pulse_intr();
    intr_in = 1'b1;
    cycles(3);
    intr_in = 1'b0;
    cycles(3);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("pkg_done within budget", int'(done_seen >= target), 1);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (bytes_seen < target && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("byte count within budget", int'(bytes_seen >= target), 1);
  endtask

  // FE FF 00 01 wraps legally; 05 after 01 is one error, 06 after 05 is fine.
  logic [7:0] wrap_seq [PKG_BYTES] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08,
                                       8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};

  initial begin
    for (int i = 0; i < PKG_BYTES; i++) slave_bytes[i] = 8'h00;

    // Reset values.
    cycles(3);
    check("reset cs_n", int'(cs_n), 1);
    check("reset sck", int'(sck), 0);
    check("reset byte_out", int'(byte_out), 0);
    check("reset byte_valid", int'(byte_valid), 0);
    check("reset byte_cnt", int'(byte_cnt), 0);
    check("reset pkg_done", int'(pkg_done), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset err_cnt", int'(err_cnt), 0);
    sys_rst_n = 1'b1;
    start_en  = 1'b1;
    cycles(4);

    // Single package 0x10..0x1F.
    load_inc(8'h10);
    push_exp(0);
    pulse_intr();
    wait_done(1);
    cycles(2);
    check("byte_cnt after pkg", int'(byte_cnt), 16);
    cycles(CS_GAP + 4);

    // Wrap and pattern error with resync.
    for (int i = 0; i < PKG_BYTES; i++) slave_bytes[i] = wrap_seq[i];
    push_exp(1);
    pulse_intr();
    wait_bytes(PKG_BYTES + 4);
    check("err_cnt after legal wrap", int'(err_cnt), 0);
    wait_done(2);
    cycles(CS_GAP + 4);
    check("overrun before overrun test", int'(overrun), 0);

    // Overrun: second edge during SHIFT is ignored.
    load_inc(8'h20);
    push_exp(1);
    pulse_intr();
    cycles(100);
    pulse_intr();
    cycles(2);
    check("overrun after edge in SHIFT", int'(overrun), 1);
    wait_done(3);
    cycles(CS_GAP + 20);

    // start_en dropped in byte 3: package still completes, then IDLE.
    load_inc(8'h30);
    push_exp(1);
    pulse_intr();
    wait_bytes(3 * PKG_BYTES + 3);
    start_en = 1'b0;
    wait_done(4);
    cycles(CS_GAP + 4);
    check("busy after disarm", int'(busy), 0);
    pulse_intr();
    cycles(50);
    check("cs_n idle after disarm", int'(cs_n), 1);
    check("cs_n falls after disarm", cs_falls, exp_falls);

    // Back-to-back: edge during GAP ignored, next edge starts a package.
    start_en = 1'b1;
    cycles(4);
    load_inc(8'h40);
    push_exp(1);
    pulse_intr();
    wait_done(5);
    intr_in = 1'b1;
    cycles(2);
    intr_in = 1'b0;
    cycles(CS_GAP + 4);
    check("no package from GAP edge", int'(cs_n), 1);
    load_inc(8'h50);
    push_exp(1);
    pulse_intr();
    wait_done(6);
    cycles(CS_GAP + 4);
    check("leftover expected bytes", exp_bytes.size(), 0);
    check("total cs_n falls", cs_falls, exp_falls);

    // Asynchronous reset in the middle of SHIFT.
    load_inc(8'h60);
    push_exp(1);
    pulse_intr();
    cycles(150);
    chk_len = 1'b0;
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("mid-shift reset cs_n", int'(cs_n), 1);
    check("mid-shift reset sck", int'(sck), 0);
    check("mid-shift reset byte_out", int'(byte_out), 0);
    check("mid-shift reset byte_valid", int'(byte_valid), 0);
    check("mid-shift reset byte_cnt", int'(byte_cnt), 0);
    check("mid-shift reset pkg_done", int'(pkg_done), 0);
    check("mid-shift reset busy", int'(busy), 0);
    check("mid-shift reset overrun", int'(overrun), 0);
    check("mid-shift reset err_cnt", int'(err_cnt), 0);
    exp_bytes.delete();
    exp_done_err.delete();
    cycles(3);
    sys_rst_n = 1'b1;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
